sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, SHALL set the number of ROM requester ports; port 0 has the highest fixed priority.
REQ-002 Parameter ADDR_WIDTH, default 23, SHALL set the SDRAM word address width.
REQ-003 Parameter STARVE_LIMIT, default 8, SHALL set the lost-arbitration count that promotes a port (see Configuration).
REQ-004 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 port_req  input  NUM_PORTS  SHALL carry the per-port read request level.
REQ-007 port_addr  input  NUM_PORTS*ADDR_WIDTH  SHALL carry the per-port word addresses; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 port_ack  output  NUM_PORTS  SHALL carry a one-cycle acceptance pulse to the granted port.
REQ-009 port_valid  output  NUM_PORTS  SHALL carry a one-cycle read-data-valid pulse to the granted port.
REQ-010 dl_active / dl_req  input  1 / 1  SHALL carry the download-in-progress level and the one-cycle "32-bit word ready" strobe.
REQ-011 dl_addr / dl_data  input  ADDR_WIDTH / 32  SHALL carry the download word address and data.
REQ-012 sdram_req, sdram_we  output  1  SHALL carry the SDRAM request and write enable; sdram_addr  output  ADDR_WIDTH  and sdram_data  output  32  SHALL carry the SDRAM address and write data.
REQ-013 sdram_ack, sdram_valid  input  1  SHALL carry the SDRAM acceptance and read-valid pulses.
REQ-014 grant_id  output  clog2(NUM_PORTS)  and busy  output  1  SHALL report the current owner and the non-IDLE state.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DL; one SDRAM transaction SHALL be outstanding at most.
REQ-016 IDLE: dl_active=1 SHALL take priority and go to DL; otherwise, if any port_req bit is 1, the winner SHALL be latched into grant_id, its address latched, and the FSM SHALL enter REQ.
REQ-017 Winner selection SHALL be the lowest-index requesting port, unless starvation promotion applies (REQ-027).
REQ-018 sdram_req SHALL be registered: a request sampled in IDLE on edge N SHALL drive sdram_req=1 and sdram_we=0 after edge N; the latched sdram_addr SHALL be held stable until sdram_ack.
REQ-019 REQ: when sdram_ack=1, port_ack[grant_id] SHALL be 1 combinationally in that cycle, and sdram_req SHALL drop at the next edge as the FSM enters WAIT.
REQ-020 WAIT: when sdram_valid=1, port_valid[grant_id] SHALL be 1 combinationally in that cycle, and the FSM SHALL return to IDLE; re-arbitration SHALL occur on the following cycle.
REQ-021 A port deasserting port_req after the grant SHALL NOT cancel the transaction; its ack and valid SHALL still be routed.
REQ-022 DL: on each dl_req, dl_addr and dl_data SHALL be registered and sdram_req=1 and sdram_we=1 asserted next cycle, held until sdram_ack; port_ack and port_valid SHALL stay 0.
REQ-023 DL SHALL exit to IDLE only when dl_active=0 and no write is awaiting sdram_ack; dl_active rising during REQ or WAIT SHALL be serviced after the read completes.
REQ-024 sdram_ack or sdram_valid arriving in IDLE SHALL be ignored (no port pulse).

Reset
REQ-025 Reset SHALL force state IDLE, sdram_req=0, sdram_we=0, sdram_addr=0, sdram_data=0, grant_id=0, busy=0, and all starvation counters to 0.
REQ-026 Reset asserted mid-transaction SHALL discard the pending grant, and SHALL suppress port_ack and port_valid while reset=1.

Configuration
REQ-027 With STARVE_GUARD_EN defined: each port SHALL have a counter that increments when the port requests in IDLE but loses and clears when the port is granted; a port whose count reaches STARVE_LIMIT SHALL win over all non-starved ports (lowest index among the starved ports); counters SHALL saturate at STARVE_LIMIT.
REQ-028 Without STARVE_GUARD_EN: no counters SHALL be synthesized, and arbitration SHALL be pure fixed priority.

Verification
REQ-029 port_req=4'b0110, addrs 0x100/0x200 -> sdram_req one cycle later with sdram_addr=0x100 and grant_id=1; ack -> port_ack=4'b0010; valid -> port_valid=4'b0010.
REQ-030 dl_active=1, four dl_req strobes with addr 0..3 and data 0xA5A5_000n -> four writes with sdram_we=1 and no port pulses; after dl_active=0 -> IDLE.
REQ-031 STARVE_GUARD_EN, STARVE_LIMIT=8, port0 and port3 requesting continuously -> port3 granted on the 9th arbitration.
REQ-032 Reset pulse in WAIT, then sdram_valid=1 -> all outputs 0 and port_valid=0.
REQ-033 Granted port drops port_req in REQ -> ack and valid still delivered to that port; no second request issued.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Fixed-priority ROM read arbiter with a download write path onto one SDRAM port.
// Define STARVE_GUARD_EN to add per-port starvation counters that promote losing ports.
module sdram_arbiter #(
  parameter  int NUM_PORTS    = 4,
  parameter  int ADDR_WIDTH   = 23,
  parameter  int STARVE_LIMIT = 8,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [NUM_PORTS-1:0]             port_valid,
  input  logic                             dl_active,
  input  logic                             dl_req,
  input  logic [ADDR_WIDTH-1:0]            dl_addr,
  input  logic [31:0]                      dl_data,
  output logic                             sdram_req,
  output logic                             sdram_we,
  output logic [ADDR_WIDTH-1:0]            sdram_addr,
  output logic [31:0]                      sdram_data,
  input  logic                             sdram_ack,
  input  logic                             sdram_valid,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DL   = 2'd3
  } state_t;

  state_t state, state_next;

  logic                  arb;
  logic [GW-1:0]         winner;
  logic [NUM_PORTS-1:0]  starved;
  logic [ADDR_WIDTH-1:0] win_addr;

  assign arb      = (state == IDLE) && !dl_active && (|port_req);
  assign win_addr = port_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign busy     = (state != IDLE);

`ifdef STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt [NUM_PORTS];

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      starved[i] = port_req[i] && (cnt[i] == CW'(STARVE_LIMIT));
  end

  // Losers count up to the limit; the winner's count restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        cnt[i] <= '0;
    end else if (arb) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (GW'(i) == winner)
          cnt[i] <= '0;
        else if (port_req[i] && cnt[i] != CW'(STARVE_LIMIT))
          cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
`else
  assign starved = '0;
`endif

  // Lowest-index requester, overridden by the lowest-index starved one.
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (port_req[i]) winner = GW'(i);
    if (|starved) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (starved[i]) winner = GW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (dl_active)      state_next = DL;
        else if (|port_req) state_next = REQ;
      end
      REQ:  if (sdram_ack)   state_next = WAIT;
      WAIT: if (sdram_valid) state_next = IDLE;
      DL: begin
        if (!dl_active && !dl_req && (!sdram_req || sdram_ack))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdram_req  <= 1'b0;
      sdram_we   <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      grant_id   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb) begin
            grant_id   <= winner;
            sdram_addr <= win_addr;
            sdram_req  <= 1'b1;
            sdram_we   <= 1'b0;
          end
        end
        REQ:  if (sdram_ack) sdram_req <= 1'b0;
        WAIT: ;
        DL: begin
          if (dl_req) begin
            sdram_addr <= dl_addr;
            sdram_data <= dl_data;
            sdram_req  <= 1'b1;
            sdram_we   <= 1'b1;
          end else if (sdram_ack) begin
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    port_ack   = '0;
    port_valid = '0;
    if (!reset && state == REQ && sdram_ack)
      port_ack[grant_id] = 1'b1;
    if (!reset && state == WAIT && sdram_valid)
      port_valid[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read path, download writes, reset, arbitration.
// Honours STARVE_GUARD_EN when the design is built with it.
module tb_sdram_arbiter;

  localparam int NP = 4;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] port_req;
  logic [NP*AW-1:0] port_addr;
  logic [NP-1:0] port_ack;
  logic [NP-1:0] port_valid;
  logic          dl_active;
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [31:0]   dl_data;
  logic          sdram_req;
  logic          sdram_we;
  logic [AW-1:0] sdram_addr;
  logic [31:0]   sdram_data;
  logic          sdram_ack;
  logic          sdram_valid;
  logic [1:0]    grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .port_req(port_req), .port_addr(port_addr),
    .port_ack(port_ack), .port_valid(port_valid),
    .dl_active(dl_active), .dl_req(dl_req),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .sdram_req(sdram_req), .sdram_we(sdram_we),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  int exp_g;

  initial begin
    reset = 1'b1; port_req = '0; port_addr = '0;
    dl_active = 0; dl_req = 0; dl_addr = '0; dl_data = '0;
    sdram_ack = 0; sdram_valid = 0;
    nclk(); nclk();
    check("rst_req", 64'(sdram_req), 0);
    check("rst_we", 64'(sdram_we), 0);
    check("rst_addr", 64'(sdram_addr), 0);
    check("rst_data", 64'(sdram_data), 0);
    check("rst_gid", 64'(grant_id), 0);
    check("rst_busy", 64'(busy), 0);
    reset = 1'b0;

    // Two requesters: port 1 beats port 2.
    nclk();
    port_req = 4'b0110;
    port_addr[1*AW +: AW] = 23'h100;
    port_addr[2*AW +: AW] = 23'h200;
    nclk();
    check("r1_req", 64'(sdram_req), 1);
    check("r1_we", 64'(sdram_we), 0);
    check("r1_addr", 64'(sdram_addr), 64'h100);
    check("r1_gid", 64'(grant_id), 1);
    check("r1_busy", 64'(busy), 1);
    port_req = '0;
    nclk();
    check("r1_hold_req", 64'(sdram_req), 1);
    check("r1_hold_addr", 64'(sdram_addr), 64'h100);
    sdram_ack = 1; #1;
    check("r1_ack", 64'(port_ack), 64'b0010);
    nclk();
    sdram_ack = 0; #1;
    check("r1_req_drop", 64'(sdram_req), 0);
    check("r1_noack", 64'(port_ack), 0);
    sdram_valid = 1; #1;
    check("r1_valid", 64'(port_valid), 64'b0010);
    nclk();
    sdram_valid = 0;
    check("r1_idle", 64'(busy), 0);

    // Granted port withdraws its request; transaction still completes.
    port_req = 4'b0001;
    port_addr[0 +: AW] = 23'h055;
    nclk();
    check("w_gid", 64'(grant_id), 0);
    check("w_addr", 64'(sdram_addr), 64'h055);
    port_req = '0;
    sdram_ack = 1; #1;
    check("w_ack", 64'(port_ack), 64'b0001);
    nclk();
    sdram_ack = 0; sdram_valid = 1; #1;
    check("w_valid", 64'(port_valid), 64'b0001);
    nclk();
    sdram_valid = 0;
    check("w_idle", 64'(busy), 0);
    nclk();
    check("w_no_reissue", 64'(sdram_req), 0);

    // Stray SDRAM strobes in IDLE.
    sdram_ack = 1; sdram_valid = 1; #1;
    check("idle_ack", 64'(port_ack), 0);
    check("idle_valid", 64'(port_valid), 0);
    nclk();
    sdram_ack = 0; sdram_valid = 0;
    check("idle_stay", 64'(busy), 0);

    // Download takes precedence over a pending read request.
    dl_active = 1; port_req = 4'b1000;
    port_addr[3*AW +: AW] = 23'h333;
    nclk();
    port_req = '0;
    check("dl_busy", 64'(busy), 1);
    check("dl_noreq", 64'(sdram_req), 0);
    for (int n = 0; n < 4; n++) begin
      dl_req = 1; dl_addr = AW'(n); dl_data = 32'hA5A5_0000 + 32'(n);
      nclk();
      dl_req = 0;
      check("dl_req", 64'(sdram_req), 1);
      check("dl_we", 64'(sdram_we), 1);
      check("dl_addr", 64'(sdram_addr), 64'(n));
      check("dl_data", 64'(sdram_data), 64'(32'hA5A5_0000 + 32'(n)));
      if (n == 3) begin
        dl_active = 0;
        nclk();
        check("dl_wait_busy", 64'(busy), 1);
        check("dl_wait_req", 64'(sdram_req), 1);
      end
      sdram_ack = 1; #1;
      check("dl_noack", 64'(port_ack), 0);
      check("dl_novalid", 64'(port_valid), 0);
      nclk();
      sdram_ack = 0;
      check("dl_req_drop", 64'(sdram_req), 0);
    end
    check("dl_exit", 64'(busy), 0);

    // Reset while waiting for read data.
    port_req = 4'b0100;
    port_addr[2*AW +: AW] = 23'h2AA;
    nclk();
    port_req = '0;
    check("rw_gid", 64'(grant_id), 2);
    sdram_ack = 1;
    nclk();
    sdram_ack = 0;
    check("rw_wait", 64'(busy), 1);
    reset = 1; sdram_valid = 1; #1;
    check("rw_busy", 64'(busy), 0);
    check("rw_req", 64'(sdram_req), 0);
    check("rw_addr", 64'(sdram_addr), 0);
    check("rw_gid0", 64'(grant_id), 0);
    check("rw_valid_in_rst", 64'(port_valid), 0);
    nclk();
    reset = 0; #1;
    check("rw_valid_after", 64'(port_valid), 0);
    nclk();
    sdram_valid = 0;
    check("rw_idle", 64'(busy), 0);

    // Ports 0 and 3 request continuously.
    port_req = 4'b1001;
    port_addr[0 +: AW] = 23'h010;
    port_addr[3*AW +: AW] = 23'h030;
    nclk();
    for (int k = 1; k <= 10; k++) begin
`ifdef STARVE_GUARD_EN
      exp_g = (k == 9) ? 3 : 0;
`else
      exp_g = 0;
`endif
      check($sformatf("arb%0d_gid", k), 64'(grant_id), 64'(exp_g));
      check($sformatf("arb%0d_addr", k), 64'(sdram_addr),
            (exp_g == 3) ? 64'h030 : 64'h010);
      sdram_ack = 1;
      nclk();
      sdram_ack = 0; sdram_valid = 1;
      nclk();
      sdram_valid = 0;
      nclk();
    end
    port_req = '0;
    nclk(); nclk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
